// File: rtl/sram_ctrl_pkg.sv
// Shared command codes, FSM state encoding and default sizing for the SRAM sequencer.
package sram_ctrl_pkg;

  localparam int ADDR_W_DEF = 21;

  typedef enum logic [2:0] {
    CMD_NOP       = 3'd0,
    CMD_SHIFT     = 3'd1,
    CMD_READ      = 3'd2,
    CMD_WRITE     = 3'd3,
    CMD_READ_INC  = 3'd4,
    CMD_WRITE_INC = 3'd5,
    CMD_CLR_ADDR  = 3'd6,
    CMD_RSVD      = 3'd7
  } cmd_e;

  // ST_START is the acceptance cycle: pins stay idle, so registered strobes first move one edge later.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SETUP,
    ST_ACCESS,
    ST_HOLD
  } state_e;

endpackage

// File: rtl/sram_addr_reg.sv
// SRAM address register: serial MSB-first load, clear, and post-access increment (wraps).
// Single-cycle update; no backpressure (the sequencer only pulses controls while idle or leaving HOLD).
module sram_addr_reg #(
  parameter int ADDR_W = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              shift_en,
  input  logic              si,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr
);

  logic [ADDR_W-1:0] base;

  // A command accepted on the HOLD->IDLE edge acts on the already-incremented address.
  always_comb begin
    base = inc ? addr + {{(ADDR_W-1){1'b0}}, 1'b1} : addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr <= '0;
    end else if (clr) begin
      addr <= '0;
    end else if (shift_en) begin
      addr <= {base[ADDR_W-2:0], si};
    end else begin
      addr <= base;
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// AVR command sequencer for external SRAM: serial address load, single-byte read/write with wait states.
// Read data valid WAIT_CYCLES+2 cycles after the strobe edge; strobes arriving mid-access are dropped with cmd_err.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              avr_clk,
  input  logic              avr_rst_n,
  input  logic [2:0]        cmd,
  input  logic              cmd_stb,
  input  logic              avr_si,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata,
  output logic              rdata_valid,
  output logic              busy,
  output logic              cmd_err,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [7:0]        sram_dout,
  input  logic [7:0]        sram_din,
  output logic              sram_doe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n
);

  localparam logic [3:0] CNT_INIT = 4'(WAIT_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       wr_q, wr_d;
  logic       inc_q, inc_d;
  logic       do_shift, do_clr, addr_inc, dout_ld, rd_cap, err_d;
  cmd_e       cmd_c;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_d     = wr_q;
    inc_d    = inc_q;
    do_shift = 1'b0;
    do_clr   = 1'b0;
    addr_inc = 1'b0;
    dout_ld  = 1'b0;
    rd_cap   = 1'b0;
    err_d    = 1'b0;
    cmd_c    = cmd_e'(cmd);

    case (state_q)
      ST_START: state_d = ST_SETUP;
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = CNT_INIT;
      end
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_HOLD;
          rd_cap  = !wr_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_HOLD: begin
        state_d  = ST_IDLE;
        addr_inc = inc_q;
      end
      default: ;
    endcase

    // The edge leaving HOLD already counts as idle, so back-to-back accesses lose no cycle.
    if (cmd_stb) begin
      if (state_q == ST_IDLE || state_q == ST_HOLD) begin
        case (cmd_c)
          CMD_SHIFT:    do_shift = 1'b1;
          CMD_CLR_ADDR: do_clr   = 1'b1;
          CMD_RSVD:     err_d    = 1'b1;
          CMD_READ, CMD_WRITE, CMD_READ_INC, CMD_WRITE_INC: begin
            state_d = ST_START;
            wr_d    = (cmd_c == CMD_WRITE) || (cmd_c == CMD_WRITE_INC);
            inc_d   = (cmd_c == CMD_READ_INC) || (cmd_c == CMD_WRITE_INC);
            dout_ld = wr_d;
          end
          default: ;
        endcase
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge avr_clk or negedge avr_rst_n) begin
    if (!avr_rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      wr_q        <= 1'b0;
      inc_q       <= 1'b0;
      rdata       <= 8'h00;
      rdata_valid <= 1'b0;
      busy        <= 1'b0;
      cmd_err     <= 1'b0;
      sram_dout   <= 8'h00;
      sram_doe    <= 1'b0;
      sram_ce_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
      sram_we_n   <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      inc_q       <= inc_d;
      rdata_valid <= rd_cap;
      cmd_err     <= err_d;
      if (rd_cap)  rdata     <= sram_din;
      if (dout_ld) sram_dout <= wdata;
      // Pin outputs are decoded from the next state so they flip on the same edge as the state.
      busy      <= (state_d == ST_SETUP) || (state_d == ST_ACCESS) || (state_d == ST_HOLD);
      sram_ce_n <= !((state_d == ST_SETUP) || (state_d == ST_ACCESS));
      sram_oe_n <= !(!wr_d && ((state_d == ST_SETUP) || (state_d == ST_ACCESS)));
      sram_we_n <= !(wr_d && (state_d == ST_ACCESS));
      sram_doe  <= wr_d && ((state_d == ST_SETUP) || (state_d == ST_ACCESS) || (state_d == ST_HOLD));
    end
  end

  sram_addr_reg #(
    .ADDR_W(ADDR_W)
  ) u_addr (
    .clk     (avr_clk),
    .rst_n   (avr_rst_n),
    .shift_en(do_shift),
    .si      (avr_si),
    .clr     (do_clr),
    .inc     (addr_inc),
    .addr    (sram_addr)
  );

endmodule
